// File: rtl/serdes_host.sv
// rtl/serdes_host.sv - host-side sequencer for a byte-serial external adder chip
// Streams both operands out bytewise, strobes the chip, then collects the sum bytes and carry.
module serdes_host #(
  parameter int WIDTH     = 24,
  parameter int CALC_WAIT = 2,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sel,
  output logic [7:0]       byte_out,
  output logic             start_calc,
  output logic             output_result,
  output logic             sel_rca,
  input  logic [7:0]       byte_in,
  input  logic             ovf_cla,
  input  logic             ovf_rca,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH:0]   res_sum
);
  localparam int NB     = WIDTH / 8;
  localparam int RD_CYC = RD_LAT + NB;
  localparam int CNT_W  = $clog2(2 * NB + CALC_WAIT + RD_CYC);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_START, S_WAIT, S_READ, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rdy_q;
  logic [2*WIDTH-1:0] sh_q;
  logic               sel_q;
  logic [WIDTH:0]     sum_q;
  logic [WIDTH+7:0]   sum_shift;

  // Counters run down to zero so every phase ends on the same cnt_q == 0 test.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_ready      = 1'b0;
    byte_out      = 8'h00;
    start_calc    = 1'b0;
    output_result = 1'b0;
    res_valid     = 1'b0;
    sel_rca       = (state_q != S_IDLE) & sel_q;
    unique case (state_q)
      S_IDLE: begin
        op_ready = rdy_q;
        if (op_valid && rdy_q) begin
          state_d = S_SEND;
          cnt_d   = CNT_W'(2 * NB - 1);
        end
      end
      S_SEND: begin
        byte_out = sh_q[7:0];
        if (cnt_q == '0) state_d = S_START;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_START: begin
        start_calc = 1'b1;
        state_d    = S_WAIT;
        cnt_d      = CNT_W'(CALC_WAIT - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_READ;
          cnt_d   = CNT_W'(RD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_READ: begin
        output_result = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sum_shift = {byte_in, sum_q[WIDTH-1:0]};
  assign res_sum   = sum_q;

  // rdy_q keeps op_ready low during reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sh_q    <= '0;
      sel_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      if (state_q == S_IDLE && op_valid && rdy_q) begin
        sh_q  <= {op_b, op_a};
        sel_q <= op_sel;
      end else if (state_q == S_SEND) begin
        sh_q <= {8'h00, sh_q[2*WIDTH-1:8]};
      end
      // Only the last NB read cycles carry sum bytes; earlier ones cover the chip latency.
      if (state_q == S_READ && cnt_q < CNT_W'(NB)) sum_q[WIDTH-1:0] <= sum_shift[WIDTH+7:8];
      if (state_q == S_READ && cnt_q == '0) sum_q[WIDTH] <= sel_q ? ovf_rca : ovf_cla;
    end
  end
endmodule

// File: tb/tb_serdes_host.sv
// tb/tb_serdes_host.sv - scoreboard bench for serdes_host over three timing configurations
module tb_serdes_host;
  localparam int WIDTH = 24;
  localparam int NB    = WIDTH / 8;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH:0]   sum;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit done_f [3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int CW  = (g == 0) ? 2 : 1;
    localparam int RL  = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    localparam int LAT = 2 * NB + 1 + CW + RL + NB;

    logic             rst_n, op_valid, op_ready, op_sel;
    logic [WIDTH-1:0] op_a, op_b;
    logic [7:0]       byte_out, byte_in;
    logic             start_calc, output_result, sel_rca, ovf_cla, ovf_rca;
    logic             res_valid, res_ready;
    logic [WIDTH:0]   res_sum;

    serdes_host #(.WIDTH(WIDTH), .CALC_WAIT(CW), .RD_LAT(RL)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .byte_out(byte_out),
      .start_calc(start_calc), .output_result(output_result), .sel_rca(sel_rca),
      .byte_in(byte_in), .ovf_cla(ovf_cla), .ovf_rca(ovf_rca),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d %s", g, s);
    endfunction

    // Adder chip model: adds the last 2*NB bytes seen when start_calc fires,
    // returns sum bytes RL cycles after output_result rises, junk elsewhere.
    logic [2*WIDTH-1:0] hist;
    logic [WIDTH-1:0]   chip_sum;
    logic               chip_c;
    int                 rd_k = 0;
    logic [7:0]         junk;
    logic               junk_c;

    always @(posedge clk) begin
      hist   <= {byte_out, hist[2*WIDTH-1:8]};
      if (start_calc) {chip_c, chip_sum} <= {1'b0, hist[WIDTH-1:0]} + {1'b0, hist[2*WIDTH-1:WIDTH]};
      rd_k   <= output_result ? rd_k + 1 : 0;
      junk   <= 8'($urandom);
      junk_c <= 1'($urandom);
    end

    always_comb begin
      byte_in = junk;
      ovf_cla = junk_c;
      ovf_rca = ~junk_c;
      if (output_result && rd_k >= RL && rd_k < RL + NB) byte_in = chip_sum[8*(rd_k-RL) +: 8];
      if (output_result && rd_k == RL + NB - 1) begin
        ovf_rca = sel_rca ? chip_c : ~chip_c;
        ovf_cla = sel_rca ? ~chip_c : chip_c;
      end
    end

    txn_t exp_q[$];
    txn_t cur;
    bit   busy = 1'b0;
    logic rv_prev = 1'b0;
    int   cyc = 0, acc_cyc = 0, n_done = 0, n_push = 0;

    initial forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        busy    = 1'b0;
        rv_prev = 1'b0;
      end else begin
        if (start_calc || output_result)
          check(nm("start_calc/output_result overlap"), {start_calc, output_result} == 2'b11, 1'b0);
        if (busy) begin
          check(nm("sel_rca"), sel_rca, cur.sel);
          if (start_calc) begin
            check(nm("byte_out at start"), byte_out, 8'h00);
            check(nm("byte_out sequence"), hist, {cur.b, cur.a});
          end
          if (res_valid) begin
            if (!rv_prev) check(nm("latency"), cyc - acc_cyc, LAT + 1);
            check(nm("res_sum"), res_sum, cur.sum);
            check(nm("op_ready in DONE"), op_ready, 1'b0);
            if (res_ready) begin
              busy = 1'b0;
              n_done++;
            end
          end
        end else begin
          check(nm("res_valid while idle"), res_valid, 1'b0);
          if (op_valid && op_ready) begin
            if (exp_q.size() == 0) begin
              check(nm("unexpected acceptance"), 1'b1, 1'b0);
            end else begin
              cur     = exp_q.pop_front();
              busy    = 1'b1;
              acc_cyc = cyc;
            end
          end
        end
        rv_prev = res_valid;
      end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic sel, input logic [WIDTH:0] sum);
      txn_t t;
      int n = 0;
      @(negedge clk);
      op_a = a; op_b = b; op_sel = sel; op_valid = 1'b1;
      while (!op_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        check(nm("accept timeout"), 1'b1, 1'b0);
      end else begin
        t.a = a; t.b = b; t.sel = sel; t.sum = sum;
        exp_q.push_back(t);
        n_push++;
      end
      @(negedge clk);
      op_valid = 1'b0;
      op_a = 24'($urandom); op_b = 24'($urandom); op_sel = 1'($urandom);
    endtask

    task automatic wait_done(input string name);
      int n = 0;
      while (n_done != n_push && n < 300) begin
        @(negedge clk);
        n++;
      end
      check(nm(name), n_done, n_push);
    endtask

    initial begin
      rst_n = 1'b0; op_valid = 1'b0; op_a = '0; op_b = '0; op_sel = 1'b0; res_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check(nm("reset outputs"),
            {op_ready, byte_out, start_calc, output_result, sel_rca, res_valid, res_sum}, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check(nm("op_ready before first edge"), op_ready, 1'b0);
      @(posedge clk);
      #1 check(nm("op_ready after first edge"), op_ready, 1'b1);

      send(24'h000001, 24'h000002, 1'b0, 25'h0000003);
      wait_done("done cla basic");
      send(24'hFFFFFF, 24'h000001, 1'b1, 25'h1000000);
      wait_done("done rca carry");

      res_ready = 1'b0;
      send(24'h123456, 24'hABCDEF, 1'b0, 25'h0BE0245);
      begin
        int n = 0;
        while (!res_valid && n < 100) begin
          @(negedge clk);
          n++;
        end
        check(nm("res_valid reached"), res_valid, 1'b1);
      end
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        check(nm("res_valid held"), res_valid, 1'b1);
      end
      @(negedge clk);
      res_ready = 1'b1;
      #1 check(nm("op_ready in handshake cycle"), op_ready, 1'b0);
      @(negedge clk);
      #1 check(nm("op_ready after handshake"), op_ready, 1'b1);
      wait_done("done backpressure");

      send(24'h0F0F0F, 24'h010101, 1'b1, 25'h0101010);
      begin
        int n = 0;
        while (!start_calc && n < 100) begin
          @(negedge clk);
          n++;
        end
        check(nm("start_calc seen"), start_calc, 1'b1);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      n_push--;
      #1 check(nm("async reset outputs"),
               {op_ready, byte_out, start_calc, output_result, sel_rca, res_valid, res_sum}, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 4) @(negedge clk);
      send(24'h0A0B0C, 24'h102030, 1'b0, 25'h01A2B3C);
      wait_done("done after reset");

      begin
        int   got = 0;
        txn_t t;
        for (int i = 0; i < 300 && got < 3; i++) begin
          @(negedge clk);
          op_a = 24'($urandom); op_b = 24'($urandom); op_sel = 1'($urandom); op_valid = 1'b1;
          if (op_ready) begin
            t.a = op_a; t.b = op_b; t.sel = op_sel;
            t.sum = {1'b0, op_a} + {1'b0, op_b};
            exp_q.push_back(t);
            n_push++;
            got++;
          end
        end
        check(nm("streamed acceptances"), got, 3);
        @(negedge clk);
        op_valid = 1'b0;
      end
      wait_done("done streaming");
      done_f[g] = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(done_f[0] && done_f[1] && done_f[2]) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("all configurations finished", {done_f[0], done_f[1], done_f[2]}, 3'b111);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
